// File: rtl/simple_axi_burst_master.sv
// INCR burst master: latches a command, checks alignment and 4 KB crossing, then
// runs one AXI4 write or read burst while streaming beats to/from the internal bus.
module simple_axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    input  logic [LEN_WIDTH-1:0]      i_len,
    input  logic [1:0]                i_rw,
    output logic                      o_wait,
    output logic                      o_done,
    input  logic                      i_clear_done,
    output logic                      o_invalid,
    output logic                      o_error,

    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic                      i_wvalid,
    output logic                      o_wready,
    output logic [DATA_WIDTH-1:0]     o_rdata,
    output logic                      o_rvalid,
    input  logic                      i_rready,

    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awqos,

    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,

    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [1:0]                m_axi_bresp,

    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arqos,

    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IDLE_DONE,
        S_CHECK,
        S_W_ADDR,
        S_W_DATA,
        S_W_RESP,
        S_R_ADDR,
        S_R_DATA
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    is_write_q, is_write_d;
    logic                    error_q, error_d;
    logic                    invalid_q, invalid_d;

    logic                    idle_like;
    logic                    accept;
    logic                    last_beat;
    logic                    w_hs;
    logic                    r_hs;
    logic                    misaligned;
    logic                    crosses_4k;
    logic [31:0]             span_end;

    always_comb begin
        idle_like  = (state_q == S_IDLE) || (state_q == S_IDLE_DONE);
        accept     = idle_like && ((i_rw == 2'b01) || (i_rw == 2'b10));
        last_beat  = (cnt_q == len_q);
        w_hs       = (state_q == S_W_DATA) && i_wvalid && m_axi_wready;
        r_hs       = (state_q == S_R_DATA) && m_axi_rvalid && i_rready;
        misaligned = (addr_q & ALIGN_MASK) != '0;
        // Byte offset one past the last beat, relative to the start of the 4 KB page.
        span_end   = 32'(addr_q[11:0]) + (32'(len_q) + 32'd1) * 32'(STRB_WIDTH);
        crosses_4k = span_end > 32'd4096;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        error_d    = error_q;
        invalid_d  = invalid_q;

        case (state_q)
            S_IDLE, S_IDLE_DONE: begin
                if (accept) begin
                    addr_d     = i_addr;
                    len_d      = i_len;
                    is_write_d = (i_rw == 2'b01);
                    error_d    = 1'b0;
                    invalid_d  = 1'b0;
                    state_d    = S_CHECK;
                end else if ((state_q == S_IDLE_DONE) && i_clear_done) begin
                    error_d   = 1'b0;
                    invalid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_CHECK: begin
                if (misaligned || crosses_4k) begin
                    invalid_d = 1'b1;
                    error_d   = 1'b0;
                    state_d   = S_IDLE_DONE;
                end else begin
                    state_d = is_write_q ? S_W_ADDR : S_R_ADDR;
                end
            end
            S_W_ADDR: begin
                if (m_axi_awready) begin
                    cnt_d   = '0;
                    state_d = S_W_DATA;
                end
            end
            S_W_DATA: begin
                if (w_hs) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (last_beat) begin
                        state_d = S_W_RESP;
                    end
                end
            end
            S_W_RESP: begin
                if (m_axi_bvalid) begin
                    error_d   = (m_axi_bresp != RESP_OKAY);
                    invalid_d = (m_axi_bresp == RESP_DECERR);
                    state_d   = S_IDLE_DONE;
                end
            end
            S_R_ADDR: begin
                if (m_axi_arready) begin
                    cnt_d   = '0;
                    state_d = S_R_DATA;
                end
            end
            S_R_DATA: begin
                if (r_hs) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    // Errors are sticky across beats; a misplaced RLAST does not end the burst early.
                    if ((m_axi_rresp != RESP_OKAY) || (m_axi_rlast != last_beat)) begin
                        error_d = 1'b1;
                    end
                    if (m_axi_rresp == RESP_DECERR) begin
                        invalid_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = S_IDLE_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            error_q    <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            error_q    <= error_d;
            invalid_q  <= invalid_d;
        end
    end

    always_comb begin
        o_wait    = !idle_like || accept;
        o_done    = (state_q == S_IDLE_DONE);
        o_error   = error_q;
        o_invalid = invalid_q;

        m_axi_awvalid = (state_q == S_W_ADDR);
        m_axi_awaddr  = addr_q;
        m_axi_awlen   = 8'(len_q);
        m_axi_awsize  = AXSIZE;
        m_axi_awburst = 2'b01;
        m_axi_awcache = 4'b0011;
        m_axi_awprot  = 3'b000;
        m_axi_awlock  = 1'b0;
        m_axi_awqos   = 4'b0000;

        m_axi_wvalid = (state_q == S_W_DATA) && i_wvalid;
        o_wready     = (state_q == S_W_DATA) && m_axi_wready;
        m_axi_wdata  = i_wdata;
        m_axi_wstrb  = '1;
        m_axi_wlast  = (state_q == S_W_DATA) && last_beat;

        m_axi_bready = (state_q == S_W_RESP);

        m_axi_arvalid = (state_q == S_R_ADDR);
        m_axi_araddr  = addr_q;
        m_axi_arlen   = 8'(len_q);
        m_axi_arsize  = AXSIZE;
        m_axi_arburst = 2'b01;
        m_axi_arcache = 4'b0011;
        m_axi_arprot  = 3'b000;
        m_axi_arlock  = 1'b0;
        m_axi_arqos   = 4'b0000;

        o_rvalid     = (state_q == S_R_DATA) && m_axi_rvalid;
        m_axi_rready = (state_q == S_R_DATA) && i_rready;
        o_rdata      = m_axi_rdata;
    end

endmodule

// File: doc/simple_axi_burst_master.md
Name: simple_axi_burst_master

Overview:
- Parametrised successor to the single-beat AXI master. It issues INCR bursts of 1..2^LEN_WIDTH beats on a full AXI4 master port.
- Write data and read data are streamed beat-by-beat over valid/ready interfaces on the internal bus side.
- Adds alignment and 4 KB boundary checking, beat counting, RLAST checking and sticky error accumulation across beats.
- Sits between an internal controller (CPU/DMA sequencer) and the AXI interconnect.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (power of 2, 8..1024).
- ADDR_WIDTH, 32, address width in bits (at least 12).
- LEN_WIDTH, 8, width of i_len (1..8); maximum burst length is 2^LEN_WIDTH beats.

Ports:
Clock, reset and command interface:
- i_clk  in  1  global clock.
- i_rst  in  1  synchronous active-high reset.
- i_addr  in  ADDR_WIDTH  burst start address.
- i_len  in  LEN_WIDTH  beats minus 1.
- i_rw  in  2  00 idle, 01 write, 10 read, 11 reserved (treated as idle).
- o_wait  out  1  transfer active.
- o_done  out  1  burst completed; held until cleared.
- i_clear_done  in  1  clears o_done, o_error and o_invalid.
- o_invalid  out  1  request rejected, or DECERR seen.
- o_error  out  1  non-OKAY response or protocol error.

Data streams:
- i_wdata  in  DATA_WIDTH, i_wvalid  in  1, o_wready  out  1: write beat stream.
- o_rdata  out  DATA_WIDTH, o_rvalid  out  1, i_rready  in  1: read beat stream.

AXI master channels:
- AW: m_axi_awvalid out 1, awready in 1, awaddr out ADDR_WIDTH, awlen out 8, awsize out 3, awburst out 2, awcache out 4, awprot out 3, awlock out 1, awqos out 4.
- W: m_axi_wvalid out 1, wready in 1, wdata out DATA_WIDTH, wstrb out DATA_WIDTH/8, wlast out 1.
- B: m_axi_bvalid in 1, bready out 1, bresp in 2.
- AR: m_axi_arvalid out 1, arready in 1, araddr out ADDR_WIDTH, arlen out 8, arsize out 3, arburst out 2, arcache out 4, arprot out 3, arlock out 1, arqos out 4.
- R: m_axi_rvalid in 1, rready out 1, rdata in DATA_WIDTH, rresp in 2, rlast in 1.

Behaviour:

Reset and constants:
- Reset: state IDLE, beat counter 0, all valid/ready/status outputs 0, latched address/length 0.
- Constants: axsize = log2(DATA_WIDTH/8), burst = INCR (01), cache = 0011, prot = 000, lock = 0, qos = 0, wstrb all ones.
- axaddr = latched address; axlen = latched length zero-extended to 8 bits.

States: IDLE, IDLE_DONE, CHECK, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA.

Command accept:
- In IDLE or IDLE_DONE with i_rw = 01 or 10: latch i_addr, i_len and i_rw; clear o_done, o_error and o_invalid; go to CHECK.
- o_wait goes to 1 combinationally in the accept cycle.
- i_rw is ignored in all other states.

CHECK (1 cycle):
- Reject if address bits below axsize are nonzero, or if addr[11:0] + (len+1)*DATA_WIDTH/8 > 4096.
- On reject: o_invalid = 1, o_error = 0, go to IDLE_DONE. No AXI traffic is issued.
- Otherwise go to W_ADDR or R_ADDR.

Address phase:
- W_ADDR / R_ADDR: axvalid = 1 and held until axready is sampled high; then go to W_DATA / R_DATA with beat counter = 0.
- Address and length stay stable while valid is asserted.

W_DATA:
- m_axi_wvalid = i_wvalid, o_wready = m_axi_wready, m_axi_wdata = i_wdata (combinational pass-through).
- m_axi_wlast = (counter == len).
- Counter increments on each wvalid && wready.
- Beat with wlast accepted: go to W_RESP.
- The W channel never starts before AW has been accepted.

W_RESP:
- bready = 1.
- On bvalid: o_error = (bresp != OKAY), o_invalid = (bresp == DECERR); go to IDLE_DONE.

R_DATA:
- o_rvalid = m_axi_rvalid, m_axi_rready = i_rready, o_rdata = m_axi_rdata (pass-through).
- Counter increments on each handshake.
- Per beat: rresp != OKAY sets sticky o_error; DECERR also sets sticky o_invalid.
- rlast != (counter == len) sets sticky o_error.
- Handshake at counter == len: go to IDLE_DONE regardless of rlast.

Status and IDLE_DONE:
- o_error and o_invalid are registered; they change on the cycle after the causing event.
- o_done = 1 while in IDLE_DONE.
- i_clear_done with i_rw = idle: go to IDLE, clearing o_done, o_error and o_invalid.
- A new command in IDLE_DONE takes priority over i_clear_done.
- o_wait = 1 in every state except IDLE and IDLE_DONE.

Reset mid-burst: immediate return to IDLE; all valids drop the next cycle. The system-wide reset is relied on to reset the slave too.

Test Plan:
1. Write, addr 0x100, len 3, slave always ready, bresp OKAY -> 4 W beats, wlast on beat 3 only, awlen = 3, o_done = 1, o_error = 0.
2. Read, addr 0x2000, len 0, rdata 0xDEADBEEF with rlast = 1, i_rready = 1 -> o_rvalid pulses once with 0xDEADBEEF, o_done = 1.
3. Read, addr 0xFF0, len 7 (32-bit) -> crosses 4 KB: no arvalid ever, o_invalid = 1, o_done = 1 two cycles after accept; unaligned addr 0x102 gives the same result.
4. Read, len 3, rresp SLVERR on beat 1, rlast only on beat 3, i_rready toggling -> all 4 beats delivered, o_error = 1, o_invalid = 0.
5. Write with awready delayed 5 cycles and i_wvalid gaps -> awvalid held 6 cycles, no wvalid before AW handshake; bresp DECERR -> o_error = 1, o_invalid = 1.
6. Assert i_rst during W_DATA beat 2 -> next cycle all valids 0, o_wait = 0, o_done = 0; a fresh read then completes normally.
